// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream receiver slice: receive FSM state
// encoding, sideband widths, counter width and a saturating increment helper.
// ---------------------------------------------------------------------------
package axis_pkg;

    localparam int USER_W = 2;
    localparam int DEST_W = 8;
    localparam int ID_W   = 1;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // IDLE: no packet in progress, RECV: storing a packet, DROP: discarding one
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_rx_fifo.sv
// ---------------------------------------------------------------------------
// axis_rx_fifo
// Synchronous FIFO holding received beats. Head is presented combinationally
// from storage so a beat written into an empty FIFO is visible one cycle after
// the write edge. Storage is cleared on reset so the head reads as zero.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH-bit entry
//   pop        in   remove head (ignored when empty)
//   pop_data   out  current head entry
//   full       out  occupancy == DEPTH
//   empty      out  occupancy == 0
//   count      out  occupancy, log2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module axis_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (count_r == CNT_DEPTH);
    assign empty_s   = (count_r == {(AW + 1){1'b0}});
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;

    // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axi_stream_receiver.sv
// ---------------------------------------------------------------------------
// axi_stream_receiver
// AXI-Stream sink that accepts packets addressed to MY_DEST into a FIFO and
// silently discards packets for other destinations. The destination is judged
// on the first beat only; the rest of the packet follows that decision.
// Reports the length of each stored packet and counts dropped packets.
//
// Ports:
//   ACLK, ARESET            clock / synchronous active-high reset
//   TVALID/TREADY           upstream handshake
//   TDATA, TKEEP, TLAST,
//   TUSER, TID, TDEST       upstream beat fields
//   out_valid/out_ready     downstream handshake on FIFO head
//   out_data, out_keep,
//   out_last, out_user,
//   out_id                  FIFO head fields
//   pkt_done                one-cycle pulse after a stored packet's last beat
//   pkt_len                 beats in the last stored packet (saturating)
//   drop_cnt                dropped packet count (saturating)
// ---------------------------------------------------------------------------
module axi_stream_receiver
    import axis_pkg::*;
#(
    parameter int              DATA_WIDTH = 16,
    parameter int              DEPTH      = 4,
    parameter logic [DEST_W-1:0] MY_DEST  = 8'h00
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    TVALID,
    output logic                    TREADY,
    input  logic [DATA_WIDTH-1:0]   TDATA,
    input  logic [DATA_WIDTH/8-1:0] TKEEP,
    input  logic                    TLAST,
    input  logic [USER_W-1:0]       TUSER,
    input  logic [ID_W-1:0]         TID,
    input  logic [DEST_W-1:0]       TDEST,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_keep,
    output logic                    out_last,
    output logic [USER_W-1:0]       out_user,
    output logic [ID_W-1:0]         out_id,
    output logic                    pkt_done,
    output logic [CNT_W-1:0]        pkt_len,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int KEEP_W    = DATA_WIDTH / 8;
    localparam int PAYLOAD_W = DATA_WIDTH + KEEP_W + 1 + USER_W + ID_W;
    localparam int AW        = $clog2(DEPTH);
    localparam logic [AW:0] FIFO_DEPTH_C = (AW + 1)'(DEPTH);

    rx_state_t              state_r;
    rx_state_t              state_nxt_s;
    logic                   accept_s;
    logic                   wr_s;
    logic                   drop_inc_s;
    logic                   tready_s;
    logic                   full_s;
    logic                   empty_s;
    logic [AW:0]            count_s;
    logic [PAYLOAD_W-1:0]   wr_payload_s;
    logic [PAYLOAD_W-1:0]   head_s;
    logic [CNT_W-1:0]       beat_cnt_r;
    logic [CNT_W-1:0]       pkt_len_r;
    logic [CNT_W-1:0]       drop_cnt_r;
    logic                   pkt_done_r;

    // Ready is a function of registered state only. DROP never stalls since
    // nothing is stored; the full flag and occupancy are both consulted so a
    // disagreement between them blocks the write rather than overrunning.
    assign tready_s = (state_r == DROP) || (!full_s && (count_s < FIFO_DEPTH_C));
    assign accept_s = TVALID && tready_s;

    assign wr_payload_s = {TDATA, TKEEP, TLAST, TUSER, TID};

    axis_rx_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (wr_s),
        .push_data (wr_payload_s),
        .pop       (out_ready),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Next-state and write/drop decisions for the packet filter
    always_comb begin
        state_nxt_s = state_r;
        wr_s        = 1'b0;
        drop_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (TDEST == MY_DEST) begin
                        wr_s = 1'b1;
                        if (TLAST) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = RECV;
                        end
                    end else begin
                        if (TLAST) begin
                            drop_inc_s  = 1'b1;
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = DROP;
                        end
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RECV: begin
                if (accept_s) begin
                    wr_s = 1'b1;
                    if (TLAST) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RECV;
                    end
                end else begin
                    state_nxt_s = RECV;
                end
            end
            DROP: begin
                if (accept_s && TLAST) begin
                    drop_inc_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus packet length, completion pulse and drop counters
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r    <= IDLE;
            beat_cnt_r <= 16'd0;
            pkt_len_r  <= 16'd0;
            drop_cnt_r <= 16'd0;
            pkt_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pkt_done_r <= wr_s && TLAST;
            if (wr_s && TLAST) begin
                // Closing beat counts toward the length being reported
                pkt_len_r  <= sat_inc16(beat_cnt_r);
                beat_cnt_r <= 16'd0;
            end else if (wr_s) begin
                beat_cnt_r <= sat_inc16(beat_cnt_r);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (drop_inc_s) begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign TREADY    = tready_s;
    assign out_valid = !empty_s;
    assign {out_data, out_keep, out_last, out_user, out_id} = head_s;
    assign pkt_done  = pkt_done_r;
    assign pkt_len   = pkt_len_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_axi_stream_receiver.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_receiver
// Self-checking bench: table of packets plus hand-written sequences for
// back-to-back packets, backpressure and mid-packet reset. Beats expected at
// the output are queued when the receiver accepts them and compared on pop.
// ---------------------------------------------------------------------------
module tb_axi_stream_receiver;

    localparam int          DW      = 16;
    localparam int          KW      = DW / 8;
    localparam int          DEPTH   = 4;
    localparam logic [7:0]  MY_DEST = 8'h00;
    localparam int          PW      = DW + KW + 1 + 2 + 1;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic           TVALID;
    logic           TREADY;
    logic [DW-1:0]  TDATA;
    logic [KW-1:0]  TKEEP;
    logic           TLAST;
    logic [1:0]     TUSER;
    logic [0:0]     TID;
    logic [7:0]     TDEST;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [KW-1:0]  out_keep;
    logic           out_last;
    logic [1:0]     out_user;
    logic [0:0]     out_id;
    logic           pkt_done;
    logic [15:0]    pkt_len;
    logic [15:0]    drop_cnt;

    axi_stream_receiver #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MY_DEST    (MY_DEST)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .TVALID    (TVALID),
        .TREADY    (TREADY),
        .TDATA     (TDATA),
        .TKEEP     (TKEEP),
        .TLAST     (TLAST),
        .TUSER     (TUSER),
        .TID       (TID),
        .TDEST     (TDEST),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_user  (out_user),
        .out_id    (out_id),
        .pkt_done  (pkt_done),
        .pkt_len   (pkt_len),
        .drop_cnt  (drop_cnt)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    int popped = 0;
    logic [PW-1:0] sb_q[$];
    logic [PW-1:0] got;

    assign got = {out_data, out_keep, out_last, out_user, out_id};

    typedef struct {
        logic [7:0]  dest0;
        logic [7:0]  dest_rest;
        int          nbeats;
        logic [15:0] base;
        logic        exp_done;
        logic [15:0] exp_len;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sideband fields derived from data so every field varies per beat
    function automatic logic [PW-1:0] mk(input logic [15:0] d, input logic last);
        return {d, d[3], 1'b1, last, d[5:4], d[6]};
    endfunction

    task automatic send_beat(input logic [15:0] d, input logic last,
                             input logic [7:0] dest, input logic wr);
        int waited = 0;
        TDATA  = d;
        TKEEP  = {d[3], 1'b1};
        TLAST  = last;
        TUSER  = d[5:4];
        TID    = d[6];
        TDEST  = dest;
        TVALID = 1'b1;
        @(negedge ACLK);
        while (!TREADY && waited < 200) begin
            waited++;
            @(negedge ACLK);
        end
        if (!TREADY) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout: got TREADY=0 expected 1 within 200 cycles");
        end else if (wr) begin
            sb_q.push_back(mk(d, last));
        end
        @(posedge ACLK);
        #1;
        TVALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            waited++;
            @(posedge ACLK);
        end
        #1;
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard: a pop happens on the edge following this negedge
    always @(negedge ACLK) begin
        if (!ARESET && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got beat %h expected none", got);
            end else begin
                check("sb_payload", 32'(got), 32'(sb_q.pop_front()));
                popped++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic wr;
        logic [15:0] d;

        //          dest0  rest   n  base      done  len     drop
        vecs[0] = '{8'h00, 8'h00, 3, 16'h1111, 1'b1, 16'd3, 16'd0};
        vecs[1] = '{8'h05, 8'h05, 2, 16'h00A0, 1'b0, 16'd3, 16'd1};
        vecs[2] = '{8'h00, 8'h00, 1, 16'h0C01, 1'b1, 16'd1, 16'd1};
        vecs[3] = '{8'h00, 8'h00, 2, 16'h0202, 1'b1, 16'd2, 16'd1};
        vecs[4] = '{8'h07, 8'h07, 1, 16'h0033, 1'b0, 16'd2, 16'd2};
        vecs[5] = '{8'h00, 8'h33, 4, 16'h1001, 1'b1, 16'd4, 16'd2};
        vecs[6] = '{8'h09, 8'h00, 3, 16'h0101, 1'b0, 16'd4, 16'd3};

        ARESET = 1'b1; TVALID = 1'b0; TDATA = 16'h0000; TKEEP = 2'b00;
        TLAST = 1'b0; TUSER = 2'b00; TID = 1'b0; TDEST = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_tready",    32'(TREADY),    32'd1);
        check("rst_pkt_done",  32'(pkt_done),  32'd0);
        check("rst_pkt_len",   32'(pkt_len),   32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        check("rst_out_data",  32'(got),       32'd0);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;

        // Table of packets, drained with out_ready held high
        for (int i = 0; i < 7; i++) begin
            wr = (vecs[i].dest0 == MY_DEST);
            for (int b = 0; b < vecs[i].nbeats; b++) begin
                d = vecs[i].base * 16'(b + 1);
                send_beat(d, (b == vecs[i].nbeats - 1),
                          (b == 0) ? vecs[i].dest0 : vecs[i].dest_rest, wr);
            end
            check("vec_pkt_done", 32'(pkt_done), 32'(vecs[i].exp_done));
            check("vec_pkt_len",  32'(pkt_len),  32'(vecs[i].exp_len));
            check("vec_drop_cnt", 32'(drop_cnt), 32'(vecs[i].exp_drop));
            if (!wr) begin
                check("vec_drop_out_valid", 32'(out_valid), 32'd0);
                check("vec_drop_tready",    32'(TREADY),    32'd1);
            end
            @(posedge ACLK);
            #1;
            check("vec_done_one_cycle", 32'(pkt_done), 32'd0);
        end
        drain("vec_drain");

        // Single-beat packet followed back-to-back by a 2-beat packet
        send_beat(16'h5A01, 1'b1, 8'h00, 1'b1);
        check("b2b_done1", 32'(pkt_done), 32'd1);
        check("b2b_len1",  32'(pkt_len),  32'd1);
        send_beat(16'h5A02, 1'b0, 8'h00, 1'b1);
        check("b2b_done_gap", 32'(pkt_done), 32'd0);
        check("b2b_len_hold", 32'(pkt_len),  32'd1);
        send_beat(16'h5A03, 1'b1, 8'h00, 1'b1);
        check("b2b_done2", 32'(pkt_done), 32'd1);
        check("b2b_len2",  32'(pkt_len),  32'd2);
        drain("b2b_drain");

        // Backpressure: fill the FIFO, confirm stall and held head, then release
        out_ready = 1'b0;
        n0 = popped;
        for (int b = 0; b < 4; b++) begin
            send_beat(16'hB000 + 16'(b), 1'b0, 8'h00, 1'b1);
        end
        check("bp_tready_low",  32'(TREADY),    32'd0);
        check("bp_out_valid",   32'(out_valid), 32'd1);
        check("bp_head",        32'(got),       32'(sb_q[0]));
        @(posedge ACLK);
        #1;
        check("bp_head_stable", 32'(got),       32'(sb_q[0]));
        fork
            begin
                send_beat(16'hB004, 1'b0, 8'h00, 1'b1);
                send_beat(16'hB005, 1'b1, 8'h00, 1'b1);
                check("bp_pkt_len", 32'(pkt_len), 32'd6);
            end
            begin
                repeat (2) @(posedge ACLK);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_delivered", 32'(popped - n0), 32'd6);

        // Reset in the middle of a stored packet
        out_ready = 1'b0;
        send_beat(16'hC001, 1'b0, 8'h00, 1'b1);
        send_beat(16'hC002, 1'b0, 8'h00, 1'b1);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        sb_q.delete();
        ARESET = 1'b0;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_tready",    32'(TREADY),    32'd1);
        check("mr_pkt_done",  32'(pkt_done),  32'd0);
        check("mr_drop_cnt",  32'(drop_cnt),  32'd0);
        check("mr_out_data",  32'(got),       32'd0);
        out_ready = 1'b1;
        send_beat(16'hC0D5, 1'b1, 8'h05, 1'b0);
        check("mr_new_start_drop", 32'(drop_cnt), 32'd1);
        check("mr_new_start_done", 32'(pkt_done), 32'd0);
        send_beat(16'hC0D1, 1'b1, 8'h00, 1'b1);
        check("mr_after_done", 32'(pkt_done), 32'd1);
        check("mr_after_len",  32'(pkt_len),  32'd1);
        drain("mr_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
